// File: rtl/seq_scan_pkg.sv
// seq_scan_pkg
//   Shared definitions for the sequence-scan controller and its pattern
//   matcher: the controller state encoding and the default geometry.
package seq_scan_pkg;

  localparam int DATA_W_DEF  = 8;   // word width serialized per handshake
  localparam int PAT_MAX_DEF = 8;   // longest programmable pattern
  localparam int CNT_W_DEF   = 16;  // match counter width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/seq_pat_match.sv
// seq_pat_match
//   Programmable-pattern Moore sequence detector fed one bit per clock.
//   Ports:
//     clk, rst           clock, synchronous active-high reset
//     clear              frame start: empties history and bits_seen
//     bit_valid, bit_in  serial bit stream (bit_in sampled when bit_valid)
//     pattern, len       pattern (bit 0 = newest bit) and length in bits
//     overlap            1 = matches may share bits, 0 = disjoint matches
//     hit                combinational: a match is reported on the next edge
//     det_pulse          registered one-cycle match indication
//   PAT_MAX must be at least 2.
module seq_pat_match
  import seq_scan_pkg::*;
#(
  parameter int PAT_MAX = PAT_MAX_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         bit_valid,
  input  logic                         bit_in,
  input  logic [PAT_MAX-1:0]           pattern,
  input  logic [$clog2(PAT_MAX+1)-1:0] len,
  input  logic                         overlap,
  output logic                         hit,
  output logic                         det_pulse
);

  localparam int LEN_W = $clog2(PAT_MAX+1);

  logic [PAT_MAX-1:0] history_reg, history_next;
  logic [LEN_W-1:0]   bits_seen_reg, bits_seen_next, bits_base;
  logic               pending_reg;
  logic               det_pulse_reg;
  logic [LEN_W-1:0]   len_eff;
  logic [PAT_MAX-1:0] mask;
  logic               match;

  assign len_eff = (len > LEN_W'(PAT_MAX)) ? LEN_W'(PAT_MAX) : len;

  // Compare only the len_eff newest history bits.
  generate
    for (genvar gi = 0; gi < PAT_MAX; gi++) begin : g_mask
      assign mask[gi] = (LEN_W'(gi) < len_eff);
    end
  endgenerate

  assign match = (len_eff != '0) && (bits_seen_reg >= len_eff) &&
                 (((history_reg ^ pattern) & mask) == '0);

  // Evaluate the match only once per shifted bit; without this a history
  // that sits still between words would keep reporting the same match.
  assign hit = pending_reg & match;

  // Non-overlap: a reported match consumes its bits, the next needs len new ones.
  assign bits_base = (hit && !overlap) ? '0 : bits_seen_reg;

  always_comb begin
    history_next   = history_reg;
    bits_seen_next = bits_base;
    if (bit_valid) begin
      history_next   = {history_reg[PAT_MAX-2:0], bit_in};
      bits_seen_next = (bits_base == LEN_W'(PAT_MAX)) ? bits_base : bits_base + LEN_W'(1);
    end
    if (clear) begin
      history_next   = '0;
      bits_seen_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      history_reg   <= '0;
      bits_seen_reg <= '0;
      pending_reg   <= 1'b0;
      det_pulse_reg <= 1'b0;
    end else begin
      history_reg   <= history_next;
      bits_seen_reg <= bits_seen_next;
      pending_reg   <= bit_valid & ~clear;
      det_pulse_reg <= hit;
    end
  end

  assign det_pulse = det_pulse_reg;

endmodule

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl
//   Frame controller: accepts words over valid/ready, serializes them
//   MSB-first into seq_pat_match and counts matches (saturating).
//   Ports:
//     clk, rst                             clock, synchronous active-high reset
//     cfg_we, cfg_pattern, cfg_len,
//     cfg_overlap                          configuration, latched only in IDLE
//     start                                begin a frame (IDLE only)
//     in_valid, in_data, in_last, in_ready word handshake, in_last ends frame
//     busy                                 controller not IDLE
//     det_pulse                            one-cycle match indication
//     match_count, overflow                match count and sticky saturation flag
//     done                                 one-cycle end-of-frame pulse
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PAT_MAX = PAT_MAX_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [PAT_MAX-1:0]           cfg_pattern,
  input  logic [$clog2(PAT_MAX+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  input  logic                         start,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic                         busy,
  output logic                         det_pulse,
  output logic [CNT_W-1:0]             match_count,
  output logic                         overflow,
  output logic                         done
);

  localparam int LEN_W = $clog2(PAT_MAX+1);
  localparam int BC_W  = $clog2(DATA_W+1);

  state_t             state_reg, state_next;
  logic [PAT_MAX-1:0] pattern_reg;
  logic [LEN_W-1:0]   len_reg;
  logic               overlap_reg;
  logic [DATA_W-1:0]  shreg_reg;
  logic               last_q;
  logic [BC_W-1:0]    bit_cnt_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               overflow_reg;
  logic               done_reg;
  logic               frame_start;
  logic               hit;

  assign frame_start = (state_reg == IDLE) && start;

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    case (state_reg)
      IDLE:  if (start) state_next = RUN;
      RUN: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SHIFT;
      end
      SHIFT: if (bit_cnt_reg == BC_W'(1)) state_next = last_q ? DONE : RUN;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      pattern_reg  <= '0;
      len_reg      <= '0;
      overlap_reg  <= 1'b0;
      shreg_reg    <= '0;
      last_q       <= 1'b0;
      bit_cnt_reg  <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && cfg_we) begin
        pattern_reg <= cfg_pattern;
        len_reg     <= cfg_len;
        overlap_reg <= cfg_overlap;
      end
      if (state_reg == RUN && in_valid) begin
        shreg_reg   <= in_data;
        last_q      <= in_last;
        bit_cnt_reg <= BC_W'(DATA_W);
      end else if (state_reg == SHIFT) begin
        shreg_reg   <= shreg_reg << 1;
        bit_cnt_reg <= bit_cnt_reg - BC_W'(1);
      end
      // Registered so it lines up with det_pulse for a match on the final bit.
      done_reg <= (state_reg == DONE);
      if (frame_start) begin
        count_reg    <= '0;
        overflow_reg <= 1'b0;
      end else if (hit) begin
        if (&count_reg) overflow_reg <= 1'b1;
        else            count_reg    <= count_reg + CNT_W'(1);
      end
    end
  end

  seq_pat_match #(
    .PAT_MAX (PAT_MAX)
  ) u_match (
    .clk       (clk),
    .rst       (rst),
    .clear     (frame_start),
    .bit_valid (state_reg == SHIFT),
    .bit_in    (shreg_reg[DATA_W-1]),
    .pattern   (pattern_reg),
    .len       (len_reg),
    .overlap   (overlap_reg),
    .hit       (hit),
    .det_pulse (det_pulse)
  );

  assign busy        = (state_reg != IDLE);
  assign match_count = count_reg;
  assign overflow    = overflow_reg;
  assign done        = done_reg;

endmodule

// File: doc/seq_scan_ctrl.md
Name: seq_scan_ctrl

Overview:
- Frame-level controller that sequences a programmable-pattern Moore sequence detector over a word-wide input stream.
- Accepts DATA_W-bit words over a valid/ready handshake, serializes each word MSB-first, one bit per clock, into a pattern matcher, and counts the matches.
- Sits between a host/DMA word source and the status/interrupt logic.
- Replaces hard-wired single-pattern detectors with a runtime-configurable pattern, length and overlap mode.

Parameters:
- DATA_W, 8, input word width (bits serialized per word)
- PAT_MAX, 8, maximum pattern length in bits
- CNT_W, 16, width of the match counter

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- cfg_we  in  1  configuration write strobe, accepted only in IDLE
- cfg_pattern  in  PAT_MAX  pattern bits; bit 0 is the most recently received bit
- cfg_len  in  $clog2(PAT_MAX+1)  pattern length in bits
- cfg_overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping
- start  in  1  begins a frame; accepted only in IDLE
- in_valid  in  1  input word valid
- in_data  in  DATA_W  input word
- in_last  in  1  marks the final word of the frame; qualified by the handshake
- in_ready  out  1  controller can accept a word
- busy  out  1  state != IDLE
- det_pulse  out  1  one-cycle match indication
- match_count  out  CNT_W  number of matches in the current/last frame
- overflow  out  1  sticky; match_count saturated
- done  out  1  one-cycle end-of-frame pulse

Behaviour:
- Reset values:
  - state = IDLE.
  - in_ready, busy, det_pulse, done, overflow = 0.
  - match_count = 0.
  - Pattern regs = 0, len = 0, overlap = 0.
  - History and bit counters = 0.
- Reset mid-frame aborts the frame immediately with the same values; no done pulse is generated.
- Config:
  - cfg_we in IDLE latches pattern, len and overlap; cfg_we in any other state is ignored.
  - len = 0 disables detection.
  - len > PAT_MAX is clamped to PAT_MAX.
- FSM states: IDLE, RUN, SHIFT, DONE.
  - IDLE: in_ready = 0. On start, clear match_count, overflow, history and bits_seen, then go to RUN. start in any non-IDLE state is ignored.
  - RUN: in_ready = 1. On in_valid & in_ready, capture in_data into the shift register, capture in_last into last_q, load bit_cnt = DATA_W, go to SHIFT.
  - SHIFT: in_ready = 0. Each cycle:
    - shift the shift-register MSB into history: history <= {history[PAT_MAX-2:0], bit};
    - bits_seen saturates at PAT_MAX;
    - bit_cnt decrements.
    - When the final bit has shifted: go to DONE if last_q, else go to RUN.
  - DONE: done = 1 for one cycle, then go to IDLE.
- Throughput: DATA_W+1 cycles per word. A word is accepted on the cycle after the last bit of the previous word.
- History persists across word boundaries within a frame. Patterns spanning two words are detected.
- Match condition: len != 0 && bits_seen >= len && history[len-1:0] == pattern[len-1:0].
- det_pulse is registered (Moore):
  - High for exactly one cycle, on the edge after the edge that shifted the completing bit.
  - match_count increments on that same edge.
  - A match on the final bit of a frame gives det_pulse in the same cycle as done.
- Non-overlap mode: on a match, bits_seen is cleared to 0, so the next match needs len fresh bits.
- Overlap mode: bits_seen is kept.
- Saturation:
  - match_count stops at all-ones.
  - A match while saturated sets overflow; overflow stays set until the next start or rst.
  - det_pulse still pulses for every match.
- in_valid while in_ready = 0 is ignored (data must be held by the source).
- match_count holds its final value in IDLE until the next start.

Decomposition:
- Shared package seq_scan_pkg:
  - state enum (IDLE, RUN, SHIFT, DONE) and encoding constants;
  - default DATA_W, PAT_MAX and CNT_W constants.
- One sub-module: seq_pat_match.
  - Contents: history register, bits_seen, length clamp, compare, overlap handling, registered det_pulse.
  - Driven by a bit-valid and a bit input from the controller.
  - Counter and FSM stay in seq_scan_ctrl.

Test Plan:
- Pattern 4'b1011, len 4, overlap = 1; one word 8'b1011_0110 with in_last -> det_pulse after bits 4 and 7; match_count = 2; done 10 cycles after the handshake.
- Same word, overlap = 0 -> exactly one det_pulse (after bit 4); match_count = 1.
- Pattern 1011, len 4; words 8'h01 then 8'h60 (last on the second) -> one match spanning the word boundary; match_count = 1.
- CNT_W = 2; pattern 1'b1, len 1, overlap = 1; word 8'hFF -> match_count saturates at 3, overflow = 1, det_pulse high for 8 shift cycles; the next start clears match_count and overflow.
- cfg_we and start asserted during SHIFT -> ignored (config unchanged, frame continues); len = 0 frame -> no det_pulse, match_count = 0, done still pulses.
- rst asserted mid-SHIFT -> next cycle state IDLE, all outputs 0, no done; a subsequent start and frame behave normally.
